// File: rtl/mips_run_ctrl.sv
// Run-control front end for the mips789 core: button conditioning, CPU reset
// stretching and halt/run/single-step sequencing of the core's rst/pause inputs.
module mips_run_ctrl #(
    parameter int DEB_CYCLES  = 500000,
    parameter int DEB_W       = 20,
    parameter int RST_CYCLES  = 16,
    parameter int STEP_CYCLES = 1,
    parameter bit AUTORUN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_rst_n,
    input  logic btn_run_n,
    input  logic btn_step_n,
    input  logic halt_i,
    output logic cpu_rst,
    output logic pause,
    output logic led_run,
    output logic led_halt
);

    localparam int MAX_CYC = (RST_CYCLES > STEP_CYCLES) ? RST_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);

    localparam int BTN_RST  = 0;
    localparam int BTN_RUN  = 1;
    localparam int BTN_STEP = 2;

    typedef enum logic [1:0] {
        S_RST,
        S_HALT,
        S_STEP,
        S_RUN
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_step_n, btn_run_n, btn_rst_n};

    // Per button: 2-flop synchroniser, debouncer, falling-edge press pulse.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_next;
            logic             press_reg;
            logic [DEB_W-1:0] cnt_reg;
            logic [DEB_W-1:0] cnt_next;

            always_comb begin
                deb_next = deb_reg;
                cnt_next = '0;
                if (sync2_reg != deb_reg) begin
                    if (cnt_reg == DEB_LAST) begin
                        deb_next = sync2_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    deb_reg   <= 1'b1;
                    cnt_reg   <= '0;
                    press_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_reg   <= deb_next;
                    cnt_reg   <= cnt_next;
                    press_reg <= deb_reg & ~deb_next;
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] st_cnt_reg;
    logic [CNT_W-1:0] st_cnt_next;
    logic             rst_req_reg;

    // The block reset leaves a one-cycle request that re-enters S_RST exactly
    // like a reset press, so the stretch always starts on the release edge.
    always_comb begin
        state_next  = state_reg;
        st_cnt_next = (st_cnt_reg != '0) ? st_cnt_reg - 1'b1 : st_cnt_reg;
        if (press[BTN_RST] || rst_req_reg) begin
            state_next  = S_RST;
            st_cnt_next = RST_LOAD;
        end else begin
            case (state_reg)
                S_RST: begin
                    if (st_cnt_reg == '0) begin
                        state_next = AUTORUN ? S_RUN : S_HALT;
                    end
                end
                S_HALT: begin
                    if (press[BTN_RUN]) begin
                        state_next = S_RUN;
                    end else if (press[BTN_STEP]) begin
                        state_next  = S_STEP;
                        st_cnt_next = STEP_LOAD;
                    end
                end
                S_STEP: begin
                    if (st_cnt_reg == '0) begin
                        state_next = S_HALT;
                    end
                end
                S_RUN: begin
                    if (press[BTN_RUN] || halt_i) begin
                        state_next = S_HALT;
                    end
                end
                default: begin
                    state_next  = S_RST;
                    st_cnt_next = RST_LOAD;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_RST;
            st_cnt_reg  <= RST_LOAD;
            rst_req_reg <= 1'b1;
            cpu_rst     <= 1'b1;
            pause       <= 1'b1;
            led_run     <= 1'b0;
            led_halt    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            st_cnt_reg  <= st_cnt_next;
            rst_req_reg <= 1'b0;
            cpu_rst     <= (state_next == S_RST);
            pause       <= (state_next == S_RST) || (state_next == S_HALT);
            led_run     <= (state_next == S_RUN);
            led_halt    <= (state_next == S_HALT);
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: two instances (1-cycle and 4-cycle step) share the
// stimulus and are compared each cycle against a mode/timer reference model.
module tb_mips_run_ctrl;

    localparam int DEB  = 4;
    localparam int RSTC = 8;
    localparam int M_RST  = 0;
    localparam int M_HALT = 1;
    localparam int M_STEP = 2;
    localparam int M_RUN  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_rst_n = 1'b1;
    logic btn_run_n = 1'b1;
    logic btn_step_n = 1'b1;
    logic halt_i = 1'b0;

    logic cpu_rst_a, pause_a, led_run_a, led_halt_a;
    logic cpu_rst_b, pause_b, led_run_b, led_halt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .DEB_CYCLES(DEB), .DEB_W(3), .RST_CYCLES(RSTC), .STEP_CYCLES(1), .AUTORUN(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_rst_n(btn_rst_n), .btn_run_n(btn_run_n),
        .btn_step_n(btn_step_n), .halt_i(halt_i), .cpu_rst(cpu_rst_a), .pause(pause_a),
        .led_run(led_run_a), .led_halt(led_halt_a)
    );

    mips_run_ctrl #(
        .DEB_CYCLES(DEB), .DEB_W(3), .RST_CYCLES(RSTC), .STEP_CYCLES(4), .AUTORUN(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_rst_n(btn_rst_n), .btn_run_n(btn_run_n),
        .btn_step_n(btn_step_n), .halt_i(halt_i), .cpu_rst(cpu_rst_b), .pause(pause_b),
        .led_run(led_run_b), .led_halt(led_halt_b)
    );

    // Reference model: per-button streak of disagreeing samples, per-instance
    // mode plus cycles remaining in that mode.
    int         m_s1 [3];
    int         m_s2 [3];
    int         m_deb [3];
    int         m_streak [3];
    int         m_press [3];
    int         m_raw [3];
    int         m_mode [2];
    int         m_left [2];
    int         m_boot;
    logic [3:0] exp_out [2];
    logic [7:0] obs;
    logic [7:0] exp_v;

    assign obs   = {cpu_rst_b, pause_b, led_run_b, led_halt_b,
                    cpu_rst_a, pause_a, led_run_a, led_halt_a};
    assign exp_v = {exp_out[1], exp_out[0]};

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                for (int b = 0; b < 3; b++) begin
                    m_s1[b] = 1; m_s2[b] = 1; m_deb[b] = 1; m_streak[b] = 0; m_press[b] = 0;
                end
                m_boot = 1;
                for (int k = 0; k < 2; k++) m_mode[k] = M_RST;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (m_boot == 1 || m_press[0] == 1) begin
                        m_mode[k] = M_RST;
                        m_left[k] = RSTC;
                    end else if (m_mode[k] == M_RST) begin
                        m_left[k] = m_left[k] - 1;
                        if (m_left[k] == 0) m_mode[k] = M_RUN;
                    end else if (m_mode[k] == M_HALT) begin
                        if (m_press[1] == 1) m_mode[k] = M_RUN;
                        else if (m_press[2] == 1) begin
                            m_mode[k] = M_STEP;
                            m_left[k] = (k == 0) ? 1 : 4;
                        end
                    end else if (m_mode[k] == M_STEP) begin
                        m_left[k] = m_left[k] - 1;
                        if (m_left[k] == 0) m_mode[k] = M_HALT;
                    end else if (m_press[1] == 1 || halt_i) begin
                        m_mode[k] = M_HALT;
                    end
                end
                m_boot = 0;
                m_raw[0] = int'(btn_rst_n);
                m_raw[1] = int'(btn_run_n);
                m_raw[2] = int'(btn_step_n);
                for (int b = 0; b < 3; b++) begin
                    m_press[b] = 0;
                    if (m_s2[b] != m_deb[b]) begin
                        m_streak[b] = m_streak[b] + 1;
                        if (m_streak[b] == DEB) begin
                            if (m_deb[b] == 1) m_press[b] = 1;
                            m_deb[b] = m_s2[b];
                            m_streak[b] = 0;
                        end
                    end else begin
                        m_streak[b] = 0;
                    end
                    m_s2[b] = m_s1[b];
                    m_s1[b] = m_raw[b];
                end
            end
            for (int k = 0; k < 2; k++) begin
                exp_out[k] = {m_mode[k] == M_RST, m_mode[k] == M_RST || m_mode[k] == M_HALT,
                              m_mode[k] == M_RUN, m_mode[k] == M_HALT};
            end
        end
    end

    task automatic test_reset();
        int n_rst = 0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 8'b1100_1100) begin
                errors++;
                $display("FAIL reset_values cyc %0d: got %b want 11001100", i, obs);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_seq cyc %0d: got %b want %b", i, obs, exp_v);
            end
            if (cpu_rst_a) n_rst++;
        end
        checks++;
        if (n_rst != RSTC) begin
            errors++;
            $display("FAIL reset_width: got %0d want %0d", n_rst, RSTC);
        end
        checks++;
        if ({cpu_rst_a, pause_a, led_run_a} !== 3'b001) begin
            errors++;
            $display("FAIL reset_to_run: got %b want 001", {cpu_rst_a, pause_a, led_run_a});
        end
        $display("test_reset: cpu_rst held %0d cycles", n_rst);
    endtask

    task automatic test_debounce();
        int first = -1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bounce cyc %0d: got %b want %b", i, obs, exp_v);
            end
            if (i < 20 && i % 2 == 0) btn_run_n = ~btn_run_n;
        end
        checks++;
        if (led_run_a !== 1'b1) begin
            errors++;
            $display("FAIL bounce_no_press: led_run got %b want 1", led_run_a);
        end
        btn_run_n = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL run_press cyc %0d: got %b want %b", i, obs, exp_v);
            end
            if (pause_a && first < 0) first = i;
            if (i == 9) btn_run_n = 1'b1;
        end
        checks++;
        if (first != DEB + 2) begin
            errors++;
            $display("FAIL press_latency: got %0d want %0d", first, DEB + 2);
        end
        checks++;
        if (led_halt_a !== 1'b1) begin
            errors++;
            $display("FAIL press_halt: led_halt got %b want 1", led_halt_a);
        end
        $display("test_debounce: pause rose %0d cycles after first sample", first);
    endtask

    task automatic test_step(input int hold);
        int n_a = 0;
        int n_b = 0;
        int gap = $urandom_range(0, 3);
        for (int i = 0; i < gap + hold + 14; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL step hold %0d cyc %0d: got %b want %b", hold, i, obs, exp_v);
            end
            if (!pause_a) n_a++;
            if (!pause_b) n_b++;
            btn_step_n = !(i >= gap && i < gap + hold);
        end
        checks++;
        if (n_a != 1 || n_b != 4) begin
            errors++;
            $display("FAIL step_len hold %0d: got %0d/%0d want 1/4", hold, n_a, n_b);
        end
        $display("test_step: hold %0d, pause low %0d and %0d cycles", hold, n_a, n_b);
    endtask

    task automatic test_breakpoint();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL breakpoint cyc %0d: got %b want %b", i, obs, exp_v);
            end
            if (i == 21 && pause_a !== 1'b1) begin
                errors++;
                $display("FAIL halt_i_pause: got %b want 1", pause_a);
            end
            if (i == 34 && led_halt_a !== 1'b1) begin
                errors++;
                $display("FAIL halt_i_in_halt: led_halt got %b want 1", led_halt_a);
            end
            btn_run_n = !(i < 8);
            halt_i    = (i == 20 || i == 30);
        end
        checks += 2;
        $display("test_breakpoint: led_halt %b", led_halt_a);
    endtask

    task automatic test_collision();
        int n_rst = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL collision cyc %0d: got %b want %b", i, obs, exp_v);
            end
            if (i == 15 && {led_run_a, led_run_b} !== 2'b11) begin
                errors++;
                $display("FAIL run_step_tie: got %b want 11", {led_run_a, led_run_b});
            end
            if (cpu_rst_a) n_rst++;
            btn_run_n  = !(i < 8);
            btn_step_n = !(i < 8);
            btn_rst_n  = !(i >= 16 && i < 24);
            halt_i     = (i == 21);
        end
        checks += 2;
        if (n_rst != RSTC || led_run_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_halt_tie: rst %0d run %b want %0d 1", n_rst, led_run_a, RSTC);
        end
        $display("test_collision: cpu_rst held %0d cycles", n_rst);
    endtask

    task automatic test_mid_step_reset();
        int d = $urandom_range(1, 3);
        int n_rst = 0;
        int n_step = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_step cyc %0d: got %b want %b", i, obs, exp_v);
            end
            if (cpu_rst_b) n_rst++;
            if (!pause_b && !led_run_b && !cpu_rst_b) n_step++;
            btn_run_n  = !(i < 8);
            btn_step_n = !(i >= 20 && i < 30);
            btn_rst_n  = !(i >= 20 + d && i < 30);
        end
        checks++;
        if (n_rst != RSTC || n_step != d || led_run_b !== 1'b1) begin
            errors++;
            $display("FAIL mid_step_rst: rst %0d step %0d run %b want %0d %0d 1",
                     n_rst, n_step, led_run_b, RSTC, d);
        end
        $display("test_mid_step_reset: offset %0d, step %0d, cpu_rst %0d", d, n_step, n_rst);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_v);
            end
            if ($urandom_range(0, 39) == 0) btn_rst_n = ~btn_rst_n;
            if ($urandom_range(0, 7) == 0) btn_run_n = ~btn_run_n;
            if ($urandom_range(0, 7) == 0) btn_step_n = ~btn_step_n;
            halt_i = ($urandom_range(0, 9) == 0);
            rst    = !(i >= 200 && i < 202);
        end
        $display("test_random: 400 cycles");
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_step(7);
        test_step(100);
        test_breakpoint();
        test_collision();
        test_mid_step_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
